// File: rtl/fc_frame_scheduler.sv
// fc_frame_scheduler: per-image CONV -> FC1 -> FC2 sequencer over a batch, owning the c/d ping-pong buffers.
// Latency: conv_done -> fc_start 1 cycle (FC idle); fc2_done -> conv_start 1 cycle (CONV waiting); last fc2_done -> batch_done 1 cycle.
// Backpressure: CONV is parked while its write buffer is still full; FC waits for done pulses (bounded only with FC_WATCHDOG_EN).
//
// Ports: clk/srstn (sync active-low reset); batch_start/batch_size start a batch; conv_done, fc1_done, fc2_done
// are completion pulses from the engines; conv_start/fc_start are one-cycle start pulses; mem_sel selects the
// buffer pair (1: CONV writes d, FC reads c); fc_layer 0=FC1 1=FC2; busy/batch_done/img_done_cnt report batch
// progress; proto_err is sticky on stray done pulses.
// Optional: define FC_WATCHDOG_EN to enable a per-image FC timeout of TIMEOUT_CYCLES.
module fc_frame_scheduler #(
  parameter int IMG_CNT_WIDTH  = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk,
  input  logic                     srstn,
  input  logic                     batch_start,
  input  logic [IMG_CNT_WIDTH-1:0] batch_size,
  input  logic                     conv_done,
  input  logic                     fc1_done,
  input  logic                     fc2_done,
  output logic                     conv_start,
  output logic                     fc_start,
  output logic                     mem_sel,
  output logic                     fc_layer,
  output logic                     busy,
  output logic                     batch_done,
  output logic [IMG_CNT_WIDTH-1:0] img_done_cnt,
  output logic                     proto_err
);

  typedef enum logic [1:0] {C_IDLE, C_RUN, C_WAIT} conv_state_t;
  typedef enum logic [1:0] {F_IDLE, F_FC1, F_FC2}  fc_state_t;

  localparam logic [IMG_CNT_WIDTH-1:0] CNT_ONE = IMG_CNT_WIDTH'(1);

  conv_state_t              c_state;
  fc_state_t                f_state;
  logic [1:0]               buf_full;    // bit 0 = buffer c, bit 1 = buffer d
  logic                     rd_ptr;      // buffer FC consumes next; tracks write order, not mem_sel
  logic [IMG_CNT_WIDTH-1:0] size_q;
  logic [IMG_CNT_WIDTH-1:0] issued_cnt;

  logic       accept, accept_zero;
  logic       conv_fin, fc1_fin, fc2_fin, fc_retire, wd_fire, stray;
  logic       imgs_left, wr_free, rd_ready;
  logic [1:0] set_mask, clr_mask;

`ifdef FC_WATCHDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wd_cnt;

  // Zero while idle, so each image's count starts on the fc_start cycle.
  always_ff @(posedge clk) begin
    if (!srstn || f_state == F_IDLE) wd_cnt <= '0;
    else                             wd_cnt <= wd_cnt + 16'd1;
  end

  // A genuine fc2_done on the limit cycle wins over the timeout.
  assign wd_fire = (f_state != F_IDLE) && (wd_cnt == WD_LIMIT) && !fc2_fin;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_fire        = 1'b0;
`endif

  assign accept      = batch_start && !busy && (batch_size != '0);
  assign accept_zero = batch_start && !busy && (batch_size == '0);
  assign conv_fin    = conv_done && (c_state == C_RUN);
  assign fc1_fin     = fc1_done  && (f_state == F_FC1);
  assign fc2_fin     = fc2_done  && (f_state == F_FC2);
  assign fc_retire   = fc2_fin || wd_fire;
  assign stray       = (conv_done && !conv_fin) || (fc1_done && !fc1_fin) || (fc2_done && !fc2_fin);

  assign set_mask = conv_fin  ? (mem_sel ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask = fc_retire ? (rd_ptr  ? 2'b10 : 2'b01) : 2'b00;

  // Look through same-cycle set/clear so a freed or filled buffer is used on the very next edge.
  assign wr_free   = !buf_full[mem_sel] || clr_mask[mem_sel];
  assign rd_ready  = buf_full[rd_ptr]   || set_mask[rd_ptr];
  assign imgs_left = accept || (busy && (issued_cnt < size_q));

  always_ff @(posedge clk) begin
    if (!srstn) begin
      c_state      <= C_IDLE;
      f_state      <= F_IDLE;
      buf_full     <= 2'b00;
      rd_ptr       <= 1'b0;
      size_q       <= '0;
      issued_cnt   <= '0;
      conv_start   <= 1'b0;
      fc_start     <= 1'b0;
      mem_sel      <= 1'b0;
      fc_layer     <= 1'b0;
      busy         <= 1'b0;
      batch_done   <= 1'b0;
      img_done_cnt <= '0;
      proto_err    <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      fc_start   <= 1'b0;
      batch_done <= 1'b0;
      buf_full   <= (buf_full | set_mask) & ~clr_mask;

      if (accept) begin
        busy         <= 1'b1;
        size_q       <= batch_size;
        issued_cnt   <= '0;
        img_done_cnt <= '0;
        proto_err    <= 1'b0;
        rd_ptr       <= mem_sel;
      end
      if (accept_zero) batch_done <= 1'b1;
      if (stray || wd_fire) proto_err <= 1'b1;

      case (c_state)
        C_IDLE: begin
          if (imgs_left) begin
            if (wr_free) begin
              c_state    <= C_RUN;
              conv_start <= 1'b1;
            end else begin
              c_state <= C_WAIT;
            end
          end
        end
        C_WAIT: begin
          if (wr_free) begin
            c_state    <= C_RUN;
            conv_start <= 1'b1;
          end
        end
        C_RUN: begin
          if (conv_done) begin
            mem_sel <= ~mem_sel;
            if (issued_cnt < size_q) issued_cnt <= issued_cnt + CNT_ONE;
            c_state <= C_IDLE;
          end
        end
        default: c_state <= C_IDLE;
      endcase

      case (f_state)
        F_IDLE: begin
          fc_layer <= 1'b0;
          if (rd_ready) begin
            f_state  <= F_FC1;
            fc_start <= 1'b1;
          end
        end
        F_FC1: begin
          if (fc1_done) begin
            f_state  <= F_FC2;
            fc_layer <= 1'b1;
          end
        end
        F_FC2:   ;
        default: f_state <= F_IDLE;
      endcase

      // Retirement (normal or timed out) overrides the FC transitions above.
      if (fc_retire) begin
        f_state  <= F_IDLE;
        fc_layer <= 1'b0;
        rd_ptr   <= ~rd_ptr;
        if (img_done_cnt < size_q) img_done_cnt <= img_done_cnt + CNT_ONE;
        if (img_done_cnt + CNT_ONE == size_q) begin
          batch_done <= 1'b1;
          busy       <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fc_frame_scheduler.sv
// Bench for fc_frame_scheduler: engine agents with random latencies plus an event-time reference model.
module tb_fc_frame_scheduler;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         srstn;
  logic         batch_start;
  logic [W-1:0] batch_size;
  logic         conv_done, fc1_done, fc2_done;
  logic         conv_start, fc_start, mem_sel, fc_layer, busy, batch_done, proto_err;
  logic [W-1:0] img_done_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit model_sel = 1'b0;   // expected mem_sel between batches

  always #5 clk = ~clk;

  fc_frame_scheduler #(.IMG_CNT_WIDTH(W)) dut (
    .clk(clk), .srstn(srstn), .batch_start(batch_start), .batch_size(batch_size),
    .conv_done(conv_done), .fc1_done(fc1_done), .fc2_done(fc2_done),
    .conv_start(conv_start), .fc_start(fc_start), .mem_sel(mem_sel), .fc_layer(fc_layer),
    .busy(busy), .batch_done(batch_done), .img_done_cnt(img_done_cnt), .proto_err(proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int rnd(int lo, int hi);
    return int'($urandom_range(hi, lo));
  endfunction

  task automatic clear_inputs();
    batch_start = 1'b0;
    batch_size  = '0;
    conv_done   = 1'b0;
    fc1_done    = 1'b0;
    fc2_done    = 1'b0;
  endtask

  // Event times are the cycles in which a pulse is driven (inputs) or observed (outputs).
  task automatic run_batch(input string name, input int size,
                           input int clo, input int chi, input int f1lo, input int f1hi,
                           input int f2lo, input int f2hi, input bit align, input bit inj,
                           input bit ign, input int abort_img, output bit aborted, output int sims);
    int cd_t[16];
    int f2_t[16];
    int ncs = 0, nfs = 0, ncd = 0, nf1 = 0, nf2 = 0;
    int conv_due = -1, f1_due = -1, f2_due = -1, inj_t = -1;
    int t0, n;
    bit base, e_cs, e_fs, e_bd;
    aborted = 1'b0;
    sims    = 0;
    base    = model_sel;
    batch_start = 1'b1;
    batch_size  = W'(size);
    t0 = cyc;
    tick();
    forever begin
      n = cyc;
      clear_inputs();
      if (abort_img >= 0 && nf1 == abort_img + 1 && nf2 == abort_img) begin
        aborted = 1'b1;
        break;
      end
      if (n - t0 > 4000) begin
        n_vec++; n_err++;
        $display("FAIL %s timeout cyc %0d images_done got %0d want %0d", name, n, nf2, size);
        break;
      end
      e_cs = 1'b0;
      if (ncs < size && ncd >= ncs) begin
        if (ncs == 0)            e_cs = (n == t0 + 1);
        else if (ncs == 1)       e_cs = (n == cd_t[0] + 2);
        else if (nf2 >= ncs - 1) e_cs = (n == imax(cd_t[ncs-1] + 2, f2_t[ncs-2] + 1));
      end
      e_fs = 1'b0;
      if (nfs < size && ncd > nfs) begin
        if (nfs == 0)        e_fs = (n == cd_t[0] + 1);
        else if (nf2 >= nfs) e_fs = (n == imax(cd_t[nfs] + 1, f2_t[nfs-1] + 2));
      end
      e_bd = (nf2 == size) && (n == f2_t[size-1] + 1);

      n_vec++;
      if (conv_start !== e_cs) begin
        n_err++; $display("FAIL %s cyc %0d conv_start got %0b want %0b", name, n, conv_start, e_cs);
      end
      n_vec++;
      if (fc_start !== e_fs) begin
        n_err++; $display("FAIL %s cyc %0d fc_start got %0b want %0b", name, n, fc_start, e_fs);
      end
      n_vec++;
      if (mem_sel !== (base ^ ncd[0])) begin
        n_err++; $display("FAIL %s cyc %0d mem_sel got %0b want %0b", name, n, mem_sel, base ^ ncd[0]);
      end
      n_vec++;
      if (fc_layer !== (nf1 > nf2)) begin
        n_err++; $display("FAIL %s cyc %0d fc_layer got %0b want %0b", name, n, fc_layer, nf1 > nf2);
      end
      n_vec++;
      if (busy !== (nf2 < size)) begin
        n_err++; $display("FAIL %s cyc %0d busy got %0b want %0b", name, n, busy, nf2 < size);
      end
      n_vec++;
      if (batch_done !== e_bd) begin
        n_err++; $display("FAIL %s cyc %0d batch_done got %0b want %0b", name, n, batch_done, e_bd);
      end
      n_vec++;
      if (img_done_cnt !== W'(nf2)) begin
        n_err++; $display("FAIL %s cyc %0d img_done_cnt got %0d want %0d", name, n, img_done_cnt, nf2);
      end
      n_vec++;
      if (proto_err !== (inj_t >= 0)) begin
        n_err++; $display("FAIL %s cyc %0d proto_err got %0b want %0b", name, n, proto_err, inj_t >= 0);
      end

      if (nf2 == size && n >= f2_t[size-1] + 3) break;

      if (conv_start && ncs < size) begin
        ncs++;
        conv_due = (align && f2_due > n) ? f2_due : n + rnd(clo, chi);
      end
      if (fc_start && nfs < size) begin
        nfs++;
        f1_due = n + rnd(f1lo, f1hi);
        f2_due = f1_due + rnd(f2lo, f2hi);
      end
      if (n == conv_due) begin
        conv_done = 1'b1; cd_t[ncd] = n; ncd++; conv_due = -1;
        if (ign) begin
          batch_start = 1'b1;
          batch_size  = W'(size + 1);
        end
      end
      if (n == f1_due) begin
        fc1_done = 1'b1; nf1++; f1_due = -1;
      end
      if (n == f2_due) begin
        fc2_done = 1'b1; f2_t[nf2] = n; nf2++; f2_due = -1;
        if (conv_done) sims++;
      end
      if (inj && n == t0 + 1) begin
        fc1_done = 1'b1;
        inj_t    = n;
      end
      tick();
    end
    clear_inputs();
    model_sel = base ^ ncd[0];
  endtask

  task automatic test_reset();
    clear_inputs();
    srstn = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({conv_start, fc_start, mem_sel, fc_layer, busy, batch_done, proto_err, img_done_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %b want all zero",
               {conv_start, fc_start, mem_sel, fc_layer, busy, batch_done, proto_err, img_done_cnt});
    end
    srstn = 1'b1;
    tick();
    model_sel = 1'b0;
  endtask

  task automatic test_zero_batch();
    batch_start = 1'b1;
    batch_size  = '0;
    tick();
    clear_inputs();
    n_vec++;
    if (batch_done !== 1'b1) begin n_err++; $display("FAIL zero_batch batch_done got %0b want 1", batch_done); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL zero_batch busy got %0b want 0", busy); end
    n_vec++;
    if (conv_start !== 1'b0) begin n_err++; $display("FAIL zero_batch conv_start got %0b want 0", conv_start); end
    tick();
    n_vec++;
    if (batch_done !== 1'b0) begin n_err++; $display("FAIL zero_batch pulse_width got %0b want 0", batch_done); end
  endtask

  task automatic test_single();
    bit ab; int s;
    run_batch("single", 1, 3, 3, 4, 4, 5, 5, 1'b0, 1'b0, 1'b0, -1, ab, s);
  endtask

  task automatic test_slow_fc();
    bit ab; int s;
    run_batch("slow_fc", 3, 50, 50, 100, 100, 100, 100, 1'b0, 1'b0, 1'b0, -1, ab, s);
  endtask

  task automatic test_simultaneous();
    bit ab; int s;
    run_batch("simultaneous", 4, 1, 3, 5, 10, 5, 10, 1'b1, 1'b0, 1'b1, -1, ab, s);
    n_vec++;
    if (s < 1) begin n_err++; $display("FAIL simultaneous coincident_events got %0d want >=1", s); end
  endtask

  task automatic test_proto_err();
    bit ab; int s;
    run_batch("proto_err", 2, 2, 6, 2, 6, 2, 6, 1'b0, 1'b1, 1'b0, -1, ab, s);
    run_batch("proto_clear", 1, 2, 6, 2, 6, 2, 6, 1'b0, 1'b0, 1'b0, -1, ab, s);
  endtask

  task automatic test_random();
    bit ab; int s;
    for (int b = 0; b < 6; b++)
      run_batch("random", rnd(1, 6), 1, 12, 1, 15, 1, 25, bit'(rnd(0, 1)), 1'b0, bit'(rnd(0, 1)), -1, ab, s);
  endtask

  task automatic test_reset_mid();
    bit ab; int s;
    run_batch("reset_mid", 4, 2, 5, 3, 6, 20, 30, 1'b0, 1'b0, 1'b0, 1, ab, s);
    n_vec++;
    if (ab !== 1'b1) begin n_err++; $display("FAIL reset_mid reached_fc2 got %0b want 1", ab); end
    srstn = 1'b0;
    tick();
    srstn = 1'b1;
    n_vec++;
    if ({conv_start, fc_start, mem_sel, fc_layer, busy, batch_done, proto_err, img_done_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_mid outputs got %b want all zero",
               {conv_start, fc_start, mem_sel, fc_layer, busy, batch_done, proto_err, img_done_cnt});
    end
    model_sel = 1'b0;
    fc2_done = 1'b1;
    tick();
    fc2_done = 1'b0;
    n_vec++;
    if (proto_err !== 1'b1) begin n_err++; $display("FAIL reset_mid stray_fc2 proto_err got %0b want 1", proto_err); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_vec++;
      if ({batch_done, busy, conv_start, fc_start} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_mid quiet cyc %0d {batch_done,busy,conv_start,fc_start} got %b want 0000",
                 cyc, {batch_done, busy, conv_start, fc_start});
      end
    end
  endtask

  initial begin
    clear_inputs();
    srstn = 1'b0;
    test_reset();
    test_zero_batch();
    test_single();
    test_slow_fc();
    test_simultaneous();
    test_proto_err();
    test_random();
    test_reset_mid();
    test_single();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc %0d reached limit", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
